// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one host-memory port between two masters, whole transactions at a time.
// Latency: accept at t, memory request pulse at t+1, first data beat no earlier than t+2; one IDLE cycle between transactions.
// Backpressure: cN_req_ready only in IDLE for the winner; read beats stall on the owner's rd_ready, write beats follow the owner's wr_valid.
//
// Ports:
//   clock, reset                    single clock, synchronous active-high reset
//   cN_req_valid/ready/opcode/len/addr   client N request handshake (N = 0, 1)
//   cN_wr_valid/bits                 client N write beats (only the owner's reach memory)
//   cN_rd_valid/bits/ready           client N read beats (only the owner sees valid)
//   mem_req_valid/opcode/len/addr    one-cycle request pulse with latched fields
//   mem_wr_valid/bits                write beats to memory
//   mem_rd_valid/bits/ready          read beats from memory
module mem_arbiter #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     c0_req_valid,
    output logic                     c0_req_ready,
    input  logic                     c0_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
    input  logic                     c0_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
    output logic                     c0_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
    input  logic                     c0_rd_ready,

    input  logic                     c1_req_valid,
    output logic                     c1_req_ready,
    input  logic                     c1_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
    input  logic                     c1_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
    output logic                     c1_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
    input  logic                     c1_rd_ready,

    output logic                     mem_req_valid,
    output logic                     mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]  mem_req_len,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    input  logic                     mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    output logic                     mem_rd_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic                     owner;       // 0 = client 0 owns the port, 1 = client 1
    logic                     last_grant;  // resets to 1 so client 0 wins the first tie
    logic                     opcode_q;
    logic [MEM_LEN_BITS-1:0]  len_q;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic [MEM_LEN_BITS-1:0]  cnt;

    logic                     any_req;
    logic                     winner;
    logic                     owner_rd_ready;
    logic                     owner_wr_valid;
    logic                     last_beat;
    logic                     beat;

    assign any_req        = c0_req_valid | c1_req_valid;
    // Tie goes to the client that did not win last time; otherwise the sole requester.
    assign winner         = (c0_req_valid & c1_req_valid) ? ~last_grant : c1_req_valid;
    assign owner_rd_ready = owner ? c1_rd_ready : c0_rd_ready;
    assign owner_wr_valid = owner ? c1_wr_valid : c0_wr_valid;
    // Unsigned compare at len width: len = all-ones ends after 2**MEM_LEN_BITS beats without wrapping.
    assign last_beat      = (cnt == len_q);
    assign beat           = ((state == RD) & mem_rd_valid & owner_rd_ready) |
                            ((state == WR) & owner_wr_valid);

    assign c0_rd_bits     = mem_rd_bits;
    assign c1_rd_bits     = mem_rd_bits;
    assign mem_wr_bits    = owner ? c1_wr_bits : c0_wr_bits;
    assign mem_req_opcode = opcode_q;
    assign mem_req_len    = len_q;
    assign mem_req_addr   = addr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        c0_req_ready  = 1'b0;
        c1_req_ready  = 1'b0;
        c0_rd_valid   = 1'b0;
        c1_rd_valid   = 1'b0;
        mem_req_valid = 1'b0;
        mem_wr_valid  = 1'b0;
        mem_rd_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    c0_req_ready = ~winner;
                    c1_req_ready = winner;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                state_nxt     = opcode_q ? WR : RD;
            end
            RD: begin
                mem_rd_ready = owner_rd_ready;
                c0_rd_valid  = mem_rd_valid & ~owner;
                c1_rd_valid  = mem_rd_valid & owner;
                if (mem_rd_valid && owner_rd_ready && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                mem_wr_valid = owner_wr_valid;
                if (owner_wr_valid && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are sampled only at the accept; changes while waiting are harmless.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            opcode_q   <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
            cnt        <= '0;
        end else if ((state == IDLE) && any_req) begin
            owner      <= winner;
            last_grant <= winner;
            opcode_q   <= winner ? c1_req_opcode : c0_req_opcode;
            len_q      <= winner ? c1_req_len    : c0_req_len;
            addr_q     <= winner ? c1_req_addr   : c0_req_addr;
            cnt        <= '0;
        end else if (beat && !last_beat) begin
            cnt <= cnt + MEM_LEN_BITS'(1);
        end
    end

endmodule
